// File: rtl/cond_flags_unit_if.sv
// E-stage request bundle into the condition/flags unit and the gated M-stage controls out of it.
interface cond_flags_unit_if;
  logic       stall_i;
  logic       flush_i;
  logic       valid_i;
  logic [3:0] cond_i;
  logic [1:0] flagwrite_i;
  logic [3:0] alu_flags_i;
  logic       regwrite_i;
  logic       memwrite_i;
  logic       pcsrc_i;
  logic       condex_o;
  logic [3:0] flags_o;
  logic       valid_o;
  logic       regwrite_o;
  logic       memwrite_o;
  logic       pcsrc_o;

  modport master (
    output stall_i, flush_i, valid_i, cond_i, flagwrite_i, alu_flags_i,
           regwrite_i, memwrite_i, pcsrc_i,
    input  condex_o, flags_o, valid_o, regwrite_o, memwrite_o, pcsrc_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, cond_i, flagwrite_i, alu_flags_i,
           regwrite_i, memwrite_i, pcsrc_i,
    output condex_o, flags_o, valid_o, regwrite_o, memwrite_o, pcsrc_o
  );
endinterface

// File: rtl/cond_flags_unit.sv
// NZCV flags register, ARM-style condition evaluation and gating of E-stage
// write/branch controls into the M-stage pipeline register.
module cond_flags_unit #(
  parameter bit NV_TRUE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cond_flags_unit_if.slave  bus
);

  localparam int unsigned FLAGS_W = 4;

  logic [FLAGS_W-1:0] flags_q;
  logic               condex;
  logic               flag_en;
  logic               valid_q;
  logic               regwrite_q;
  logic               memwrite_q;
  logic               pcsrc_q;
  logic               n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluated against the stored flags only; no ALU forwarding.
  always_comb begin
    condex = 1'b0;
    unique case (bus.cond_i)
      4'b0000: condex = z_f;
      4'b0001: condex = ~z_f;
      4'b0010: condex = c_f;
      4'b0011: condex = ~c_f;
      4'b0100: condex = n_f;
      4'b0101: condex = ~n_f;
      4'b0110: condex = v_f;
      4'b0111: condex = ~v_f;
      4'b1000: condex = c_f & ~z_f;
      4'b1001: condex = ~c_f | z_f;
      4'b1010: condex = (n_f == v_f);
      4'b1011: condex = (n_f != v_f);
      4'b1100: condex = ~z_f & (n_f == v_f);
      4'b1101: condex = z_f | (n_f != v_f);
      4'b1110: condex = 1'b1;
      4'b1111: condex = NV_TRUE;
      default: condex = 1'b0;
    endcase
  end

  assign flag_en = bus.valid_i & condex & ~bus.stall_i & ~bus.flush_i;

  // N,Z and C,V halves commit independently at the end of the E cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (flag_en) begin
      if (bus.flagwrite_i[1]) flags_q[3:2] <= bus.alu_flags_i[3:2];
      if (bus.flagwrite_i[0]) flags_q[1:0] <= bus.alu_flags_i[1:0];
    end
  end

  // M-stage register: flush beats stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      pcsrc_q    <= 1'b0;
    end else if (bus.flush_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      pcsrc_q    <= 1'b0;
    end else if (!bus.stall_i) begin
      valid_q    <= bus.valid_i;
      regwrite_q <= bus.regwrite_i & condex & bus.valid_i;
      memwrite_q <= bus.memwrite_i & condex & bus.valid_i;
      pcsrc_q    <= bus.pcsrc_i & condex & bus.valid_i;
    end
  end

  assign bus.condex_o   = condex;
  assign bus.flags_o    = flags_q;
  assign bus.valid_o    = valid_q;
  assign bus.regwrite_o = regwrite_q;
  assign bus.memwrite_o = memwrite_q;
  assign bus.pcsrc_o    = pcsrc_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit: one instance per NV_TRUE setting.
module tb_cond_flags_unit;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  cond_flags_unit_if ia ();
  cond_flags_unit_if ib ();

  cond_flags_unit #(.NV_TRUE(1'b0)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ia));
  cond_flags_unit #(.NV_TRUE(1'b1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic rw, input logic mw, input logic pc);
    ia.valid_i     = v;
    ia.cond_i      = c;
    ia.flagwrite_i = fw;
    ia.alu_flags_i = af;
    ia.regwrite_i  = rw;
    ia.memwrite_i  = mw;
    ia.pcsrc_i     = pc;
    #1;
  endtask

  task automatic m_outs(input string tag, input logic v, input logic rw,
                        input logic mw, input logic pc);
    chk({tag, ".valid"},    4'(ia.valid_o),    4'(v));
    chk({tag, ".regwrite"}, 4'(ia.regwrite_o), 4'(rw));
    chk({tag, ".memwrite"}, 4'(ia.memwrite_o), 4'(mw));
    chk({tag, ".pcsrc"},    4'(ia.pcsrc_o),    4'(pc));
  endtask

  initial begin
    rst_n = 1'b0;
    ia.stall_i = 1'b0; ia.flush_i = 1'b0;
    ib.stall_i = 1'b0; ib.flush_i = 1'b0;
    ib.valid_i = 1'b0; ib.cond_i = 4'b1111; ib.flagwrite_i = 2'b00;
    ib.alu_flags_i = 4'b0000; ib.regwrite_i = 1'b0; ib.memwrite_i = 1'b0; ib.pcsrc_i = 1'b0;
    drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset state and condition decode against zero flags
    step(); step();
    chk("rst.flags", ia.flags_o, 4'b0000);
    m_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.eq", 4'(ia.condex_o), 4'd0);
    drive(1'b0, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst.ne", 4'(ia.condex_o), 4'd1);
    step();
    rst_n = 1'b1;

    // AL instruction loads flags 0110
    drive(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0);
    step();
    chk("al.flags", ia.flags_o, 4'b0110);
    chk("al.valid", 4'(ia.valid_o), 4'd1);
    drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("eq.z1", 4'(ia.condex_o), 4'd1);
    drive(1'b0, 4'b1000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("hi.z1", 4'(ia.condex_o), 4'd0);

    // Failed condition must not write flags or regwrite
    drive(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld0100", ia.flags_o, 4'b0100);
    drive(1'b1, 4'b0001, 2'b11, 4'b1001, 1'b1, 1'b0, 1'b0);
    step();
    chk("nefail.flags", ia.flags_o, 4'b0100);
    m_outs("nefail", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 2'b11, 4'b1001, 1'b1, 1'b0, 1'b0);
    step();
    chk("eqpass.flags", ia.flags_o, 4'b1001);
    m_outs("eqpass", 1'b1, 1'b1, 1'b0, 1'b0);

    // Independent N,Z and C,V halves
    drive(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld0000", ia.flags_o, 4'b0000);
    drive(1'b1, 4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    chk("fw10", ia.flags_o, 4'b1100);
    drive(1'b1, 4'b1110, 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    chk("fw01", ia.flags_o, 4'b1101);

    // Invalid instruction: no flag update, no gated controls
    drive(1'b0, 4'b1110, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    chk("inv.flags", ia.flags_o, 4'b1101);
    m_outs("inv", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall holds, flush beats stall, release lets LT memwrite through
    drive(1'b1, 4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld1000", ia.flags_o, 4'b1000);
    drive(1'b1, 4'b1011, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("lt.condex", 4'(ia.condex_o), 4'd1);
    ia.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall.flags", ia.flags_o, 4'b1000);
      m_outs("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    ia.flush_i = 1'b1;
    step();
    chk("flush.flags", ia.flags_o, 4'b1000);
    m_outs("flush", 1'b0, 1'b0, 1'b0, 1'b0);
    ia.stall_i = 1'b0;
    ia.flush_i = 1'b0;
    step();
    m_outs("release", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("release.flags", ia.flags_o, 4'b0000);

    // cond 1111 under both NV_TRUE settings
    drive(1'b1, 4'b1111, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1);
    ib.valid_i = 1'b1; ib.pcsrc_i = 1'b1;
    #1;
    chk("nv0.condex", 4'(ia.condex_o), 4'd0);
    chk("nv1.condex", 4'(ib.condex_o), 4'd1);
    step();
    m_outs("nv0", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nv0.flags", ia.flags_o, 4'b0000);
    chk("nv1.pcsrc", 4'(ib.pcsrc_o), 4'd1);

    // Asynchronous reset mid-cycle
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
    step();
    chk("pre_rst.flags", ia.flags_o, 4'b1111);
    m_outs("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.flags", ia.flags_o, 4'b0000);
    m_outs("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.nv1.pcsrc", 4'(ib.pcsrc_o), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
